// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM states and one-hot grant encodings for the Wishbone arbiter
package wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_ABORT
   } state_e;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_rr2.sv
// wb_arb_rr2: two-input round-robin / fixed-priority grant select (combinational)
module wb_arb_rr2
   import wb_pkg::*;
#(
   parameter int ROUND_ROBIN = 1
) (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   // a single requester wins outright; a tie goes to the master not served last (or m0 in fixed priority)
   always_comb gnt_o = (&req_i) ? ((ROUND_ROBIN != 0 && !last_i) ? GNT_M1 : GNT_M0) : req_i;

endmodule

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: two-master Wishbone arbiter sharing one RAM slave port, with watchdog abort
module wb_ram_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int ROUND_ROBIN  = 1,
   parameter int TIMEOUT      = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
   input  logic [DATA_WIDTH-1:0]   m0_dat_i,
   output logic [DATA_WIDTH-1:0]   m0_dat_o,
   input  logic                    m0_we_i,
   input  logic [SELECT_WIDTH-1:0] m0_sel_i,
   input  logic                    m0_stb_i,
   output logic                    m0_ack_o,
   output logic                    m0_err_o,
   input  logic                    m0_cyc_i,
   input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
   input  logic [DATA_WIDTH-1:0]   m1_dat_i,
   output logic [DATA_WIDTH-1:0]   m1_dat_o,
   input  logic                    m1_we_i,
   input  logic [SELECT_WIDTH-1:0] m1_sel_i,
   input  logic                    m1_stb_i,
   output logic                    m1_ack_o,
   output logic                    m1_err_o,
   input  logic                    m1_cyc_i,
   output logic [ADDR_WIDTH-1:0]   s_adr_o,
   output logic [DATA_WIDTH-1:0]   s_dat_o,
   input  logic [DATA_WIDTH-1:0]   s_dat_i,
   output logic                    s_we_o,
   output logic [SELECT_WIDTH-1:0] s_sel_o,
   output logic                    s_stb_o,
   input  logic                    s_ack_i,
   output logic                    s_cyc_o,
   output logic [1:0]              grant_o
);

   // watchdog keeps at least one bit so TIMEOUT=0 (disabled) still elaborates
   localparam int            TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

   state_e        state_q;
   logic [1:0]    grant_q;
   logic          last_q;
   logic [TW-1:0] wdog_q;
   logic [TW-1:0] wdog_d;
   logic [1:0]    arb_gnt;
   logic          act;
   logic          cyc_g;
   logic          stb_g;
   logic          hit;

   wb_arb_rr2 #(
      .ROUND_ROBIN(ROUND_ROBIN)
   ) u_arb (
      .req_i ({m1_cyc_i, m0_cyc_i}),
      .last_i(last_q),
      .gnt_o (arb_gnt)
   );

   // granted-master selects, watchdog expiry and next watchdog count
   always_comb begin
      act    = state_q == ST_ACTIVE;
      cyc_g  = grant_q[0] ? m0_cyc_i : grant_q[1] & m1_cyc_i;
      stb_g  = grant_q[0] ? m0_stb_i : grant_q[1] & m1_stb_i;
      hit    = (TIMEOUT != 0) && act && wdog_q == T_MAX;
      wdog_d = (act && stb_g && !s_ack_i) ? ((wdog_q == T_MAX) ? wdog_q : wdog_q + 1'b1) : '0;
   end

   // slave-side mux; strobe and cycle are cut on the expiry cycle so the stalled slave sees an abort
   always_comb begin
      s_adr_o = grant_q[0] ? m0_adr_i : grant_q[1] ? m1_adr_i : '0;
      s_dat_o = grant_q[0] ? m0_dat_i : grant_q[1] ? m1_dat_i : '0;
      s_we_o  = grant_q[0] ? m0_we_i  : grant_q[1] & m1_we_i;
      s_sel_o = grant_q[0] ? m0_sel_i : grant_q[1] ? m1_sel_i : '0;
      s_cyc_o = act & cyc_g & ~hit;
      s_stb_o = act & stb_g & ~hit;
      grant_o = grant_q;
   end

   // master-side returns: ack only to the owner, never together with err
   always_comb begin
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      m0_ack_o = act & grant_q[0] & s_ack_i & ~hit;
      m1_ack_o = act & grant_q[1] & s_ack_i & ~hit;
      m0_err_o = hit & grant_q[0];
      m1_err_o = hit & grant_q[1];
   end

   // arbitration FSM: grant is held for the whole CYC and only re-arbitrated from IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= GNT_NONE;
         last_q  <= 1'b1;
         wdog_q  <= '0;
      end else begin
         wdog_q <= wdog_d;
         case (state_q)
            ST_IDLE: begin
               if (m0_cyc_i | m1_cyc_i) begin
                  state_q <= ST_ACTIVE;
                  grant_q <= arb_gnt;
                  last_q  <= arb_gnt[1];
               end
            end
            ST_ACTIVE: begin
               if (!cyc_g) begin
                  state_q <= ST_IDLE;
                  grant_q <= GNT_NONE;
               end else if (hit) begin
                  state_q <= ST_ABORT;
               end
            end
            ST_ABORT: begin
               if (!cyc_g) begin
                  state_q <= ST_IDLE;
                  grant_q <= GNT_NONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= GNT_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb_wb_ram_arbiter: directed tests of grant, mux, locking, watchdog and async reset
module tb_wb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] m0_adr_i, m1_adr_i;
   logic [31:0] m0_dat_i, m1_dat_i;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        m0_we_i, m1_we_i;
   logic [3:0]  m0_sel_i, m1_sel_i;
   logic        m0_stb_i, m1_stb_i;
   logic        m0_ack_o, m1_ack_o;
   logic        m0_err_o, m1_err_o;
   logic        m0_cyc_i, m1_cyc_i;
   logic [15:0] s_adr_o;
   logic [31:0] s_dat_o;
   logic        s_we_o;
   logic [3:0]  s_sel_o;
   logic        s_stb_o;
   logic        s_cyc_o;
   logic [1:0]  grant_o;

   logic [31:0] f_m0_dat, f_m1_dat, f_s_dat;
   logic        f_m0_ack, f_m1_ack, f_m0_err, f_m1_err, f_s_we, f_s_stb, f_s_cyc;
   logic [15:0] f_s_adr;
   logic [3:0]  f_s_sel;
   logic [1:0]  f_grant;

   logic [31:0] mem [0:255];
   logic        ack_q;
   logic [31:0] rdat_q;
   logic        ack_en;

   int tests = 0;
   int fails = 0;

   always #10 clk = ~clk;

   wb_ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ROUND_ROBIN(1), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
      .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m0_cyc_i(m0_cyc_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
      .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .m1_cyc_i(m1_cyc_i),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(rdat_q), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_ack_i(ack_q), .s_cyc_o(s_cyc_o),
      .grant_o(grant_o)
   );

   // fixed-priority instance sharing all inputs; only its grant is observed
   wb_ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ROUND_ROBIN(0), .TIMEOUT(8)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(f_m0_dat), .m0_we_i(m0_we_i),
      .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err),
      .m0_cyc_i(m0_cyc_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(f_m1_dat), .m1_we_i(m1_we_i),
      .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err),
      .m1_cyc_i(m1_cyc_i),
      .s_adr_o(f_s_adr), .s_dat_o(f_s_dat), .s_dat_i(rdat_q), .s_we_o(f_s_we),
      .s_sel_o(f_s_sel), .s_stb_o(f_s_stb), .s_ack_i(ack_q), .s_cyc_o(f_s_cyc),
      .grant_o(f_grant)
   );

   // RAM slave model: one registered ack per sampled strobe, byte-lane writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q <= 1'b0;
      end else begin
         ack_q <= ack_en & s_cyc_o & s_stb_o;
         if (s_cyc_o & s_stb_o) begin
            rdat_q <= mem[s_adr_o[7:0]];
            if (s_we_o)
               for (int b = 0; b < 4; b++)
                  if (s_sel_o[b]) mem[s_adr_o[7:0]][8*b +: 8] <= s_dat_o[8*b +: 8];
         end
      end
   end

   task automatic clear_inputs();
      m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_sel_i = '0; m0_stb_i = 1'b0; m0_cyc_i = 1'b0;
      m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_sel_i = '0; m1_stb_i = 1'b0; m1_cyc_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      ack_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      tests++;
      if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_bus: grant=%b cyc=%b stb=%b, want 00 0 0", grant_o, s_cyc_o, s_stb_o);
      end
      tests++;
      if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_ack_err: ack/err=%b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
      end
      tests++;
      if (s_adr_o !== 16'h0 || s_dat_o !== 32'h0 || s_sel_o !== 4'h0 || s_we_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_mux: adr=%h dat=%h sel=%h we=%b, want all 0", s_adr_o, s_dat_o, s_sel_o, s_we_o);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_m0_write_read();
      @(negedge clk);
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
      m0_adr_i = 16'h0010; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF;
      #1;
      tests++;
      if (grant_o !== 2'b00 || s_stb_o !== 1'b0) begin
         fails++;
         $display("FAIL wr_pre_grant: grant=%b stb=%b, want 00 0", grant_o, s_stb_o);
      end
      @(negedge clk); #1;
      tests++;
      if (grant_o !== 2'b01 || s_stb_o !== 1'b1 || s_cyc_o !== 1'b1) begin
         fails++;
         $display("FAIL wr_grant: grant=%b stb=%b cyc=%b, want 01 1 1", grant_o, s_stb_o, s_cyc_o);
      end
      tests++;
      if (s_adr_o !== 16'h0010 || s_dat_o !== 32'hDEADBEEF || s_sel_o !== 4'hF || s_we_o !== 1'b1) begin
         fails++;
         $display("FAIL wr_mux: adr=%h dat=%h sel=%h we=%b, want 0010 deadbeef f 1", s_adr_o, s_dat_o, s_sel_o, s_we_o);
      end
      @(negedge clk);
      m0_stb_i = 1'b0;
      #1;
      tests++;
      if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
         fails++;
         $display("FAIL wr_ack: m0_ack=%b m1_ack=%b, want 1 0", m0_ack_o, m1_ack_o);
      end
      @(negedge clk);
      m0_stb_i = 1'b1; m0_we_i = 1'b0;
      #1;
      tests++;
      if (m0_ack_o !== 1'b0) begin
         fails++;
         $display("FAIL wr_ack_single: m0_ack=%b want 0", m0_ack_o);
      end
      @(negedge clk);
      m0_stb_i = 1'b0;
      #1;
      tests++;
      if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
         fails++;
         $display("FAIL rd_ack: m0_ack=%b m1_ack=%b, want 1 0", m0_ack_o, m1_ack_o);
      end
      tests++;
      if (m0_dat_o !== 32'hDEADBEEF || m1_dat_o !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL rd_data: m0_dat=%h m1_dat=%h, want deadbeef", m0_dat_o, m1_dat_o);
      end
      @(negedge clk);
      m0_cyc_i = 1'b0;
      #1;
      tests++;
      if (m0_ack_o !== 1'b0) begin
         fails++;
         $display("FAIL rd_ack_single: m0_ack=%b want 0", m0_ack_o);
      end
      @(negedge clk); #1;
      tests++;
      if (grant_o !== 2'b00) begin
         fails++;
         $display("FAIL wr_release: grant=%b want 00", grant_o);
      end
      clear_inputs();
   endtask

   task automatic test_rr_tie();
      do_reset();
      @(negedge clk);
      m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
      @(negedge clk); #1;
      tests++;
      if (grant_o !== 2'b01 || f_grant !== 2'b01) begin
         fails++;
         $display("FAIL tie1: rr=%b fp=%b, want 01 01", grant_o, f_grant);
      end
      @(negedge clk);
      m0_cyc_i = 1'b0;
      #1;
      tests++;
      if (grant_o !== 2'b01) begin
         fails++;
         $display("FAIL tie1_hold: grant=%b want 01", grant_o);
      end
      @(negedge clk);
      m0_cyc_i = 1'b1;
      #1;
      tests++;
      if (grant_o !== 2'b00 || f_grant !== 2'b00) begin
         fails++;
         $display("FAIL tie_bubble: rr=%b fp=%b, want 00 00", grant_o, f_grant);
      end
      @(negedge clk); #1;
      tests++;
      if (grant_o !== 2'b10 || f_grant !== 2'b01) begin
         fails++;
         $display("FAIL tie2: rr=%b fp=%b, want 10 01", grant_o, f_grant);
      end
      @(negedge clk);
      m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
      @(negedge clk); #1;
      tests++;
      if (grant_o !== 2'b00 || f_grant !== 2'b00) begin
         fails++;
         $display("FAIL tie_release: rr=%b fp=%b, want 00 00", grant_o, f_grant);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 4'hF;
      m1_adr_i = 16'h0020; m1_dat_i = 32'hA0;
      @(negedge clk);
      m0_cyc_i = 1'b1;
      #1;
      tests++;
      if (grant_o !== 2'b10 || s_stb_o !== 1'b1 || s_adr_o !== 16'h0020) begin
         fails++;
         $display("FAIL b2b_grant: grant=%b stb=%b adr=%h, want 10 1 0020", grant_o, s_stb_o, s_adr_o);
      end
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         m1_adr_i = 16'h0020 + 16'(i); m1_dat_i = 32'hA0 + 32'(i);
         #1;
         tests++;
         if (grant_o !== 2'b10 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || s_adr_o !== m1_adr_i) begin
            fails++;
            $display("FAIL b2b_beat%0d: grant=%b m1_ack=%b m0_ack=%b adr=%h, want 10 1 0 %h",
                     i, grant_o, m1_ack_o, m0_ack_o, s_adr_o, m1_adr_i);
         end
      end
      @(negedge clk);
      m1_stb_i = 1'b0;
      #1;
      tests++;
      if (grant_o !== 2'b10 || m1_ack_o !== 1'b1) begin
         fails++;
         $display("FAIL b2b_last_ack: grant=%b m1_ack=%b, want 10 1", grant_o, m1_ack_o);
      end
      @(negedge clk);
      m1_cyc_i = 1'b0;
      #1;
      tests++;
      if (grant_o !== 2'b10 || m1_ack_o !== 1'b0) begin
         fails++;
         $display("FAIL b2b_locked: grant=%b m1_ack=%b, want 10 0", grant_o, m1_ack_o);
      end
      @(negedge clk); #1;
      tests++;
      if (grant_o !== 2'b00) begin
         fails++;
         $display("FAIL b2b_bubble: grant=%b want 00", grant_o);
      end
      @(negedge clk); #1;
      tests++;
      if (grant_o !== 2'b01) begin
         fails++;
         $display("FAIL b2b_handover: grant=%b want 01", grant_o);
      end
      tests++;
      if (mem[8'h23] !== 32'hA3 || mem[8'h20] !== 32'hA0) begin
         fails++;
         $display("FAIL b2b_data: mem20=%h mem23=%h, want a0 a3", mem[8'h20], mem[8'h23]);
      end
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_timeout();
      ack_en = 1'b0;
      @(negedge clk);
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 16'h0030;
      @(negedge clk);
      m1_cyc_i = 1'b1;
      #1;
      tests++;
      if (s_stb_o !== 1'b1 || grant_o !== 2'b01 || m0_err_o !== 1'b0) begin
         fails++;
         $display("FAIL to_start: stb=%b grant=%b err=%b, want 1 01 0", s_stb_o, grant_o, m0_err_o);
      end
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk); #1;
         tests++;
         if (m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin
            fails++;
            $display("FAIL to_wait%0d: err=%b stb=%b, want 0 1", i, m0_err_o, s_stb_o);
         end
      end
      @(negedge clk); #1;
      tests++;
      if (m0_err_o !== 1'b1 || m1_err_o !== 1'b0 || m0_ack_o !== 1'b0) begin
         fails++;
         $display("FAIL to_err: m0_err=%b m1_err=%b m0_ack=%b, want 1 0 0", m0_err_o, m1_err_o, m0_ack_o);
      end
      tests++;
      if (s_stb_o !== 1'b0 || s_cyc_o !== 1'b0) begin
         fails++;
         $display("FAIL to_drop: stb=%b cyc=%b, want 0 0", s_stb_o, s_cyc_o);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         tests++;
         if (m0_err_o !== 1'b0 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0 || grant_o !== 2'b01) begin
            fails++;
            $display("FAIL to_abort%0d: err=%b stb=%b cyc=%b grant=%b, want 0 0 0 01",
                     i, m0_err_o, s_stb_o, s_cyc_o, grant_o);
         end
      end
      @(negedge clk);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      @(negedge clk); #1;
      tests++;
      if (grant_o !== 2'b00) begin
         fails++;
         $display("FAIL to_release: grant=%b want 00", grant_o);
      end
      @(negedge clk); #1;
      tests++;
      if (grant_o !== 2'b10) begin
         fails++;
         $display("FAIL to_next: grant=%b want 10", grant_o);
      end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      ack_en = 1'b0;
      @(negedge clk);
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      @(negedge clk); #1;
      tests++;
      if (s_stb_o !== 1'b1 || s_cyc_o !== 1'b1) begin
         fails++;
         $display("FAIL ar_pre: stb=%b cyc=%b, want 1 1", s_stb_o, s_cyc_o);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (s_stb_o !== 1'b0 || s_cyc_o !== 1'b0 || grant_o !== 2'b00) begin
         fails++;
         $display("FAIL ar_drop: stb=%b cyc=%b grant=%b, want 0 0 00", s_stb_o, s_cyc_o, grant_o);
      end
      tests++;
      if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
         fails++;
         $display("FAIL ar_no_resp: ack/err=%b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
      end
      @(negedge clk);
      m1_cyc_i = 1'b1; ack_en = 1'b1; rst_n = 1'b1;
      #1;
      tests++;
      if (grant_o !== 2'b00 || m0_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
         fails++;
         $display("FAIL ar_release: grant=%b ack=%b err=%b, want 00 0 0", grant_o, m0_ack_o, m0_err_o);
      end
      @(negedge clk); #1;
      tests++;
      if (grant_o !== 2'b01 || f_grant !== 2'b01) begin
         fails++;
         $display("FAIL ar_tie: rr=%b fp=%b, want 01 01", grant_o, f_grant);
      end
      clear_inputs();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      ack_en = 1'b1;
      clear_inputs();
      test_reset();
      test_m0_write_read();
      test_rr_tie();
      test_back_to_back();
      test_timeout();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
